measure_ctrl: RTL and testbench

Sequencer for the frequency-measure datapath. Latches software configuration, arms the measure block's gate (single-shot or continuous), captures each 64-bit count result into a result holding register with a valid/ack handshake, and flags timeouts (no signal) and overruns. Sits between the AXI register file and the measure block in the DFM core.

---
 rtl/dfm_pkg.sv | 28 ++
 rtl/measure_result_reg.sv | 37 +++
 rtl/measure_ctrl.sv | 126 ++++++++++++
 tb/tb_measure_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dfm_pkg.sv
// Shared types and constants for the DFM measure sequencer.
// Result word: reference count in the upper half, signal count below.
package dfm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int REF_CNT_MSB = 63;
  localparam int SIG_CNT_MSB = 31;
  localparam int RES_W       = REF_CNT_MSB + 1;

  function automatic logic [SIG_CNT_MSB:0] ref_cnt(
    input logic [REF_CNT_MSB:0] res
  );
    return res[REF_CNT_MSB:SIG_CNT_MSB+1];
  endfunction

  function automatic logic [SIG_CNT_MSB:0] sig_cnt(
    input logic [REF_CNT_MSB:0] res
  );
    return res[SIG_CNT_MSB:0];
  endfunction

endpackage

// File: rtl/measure_result_reg.sv
// Result holding register with valid/ack handshake.
// Flags an overrun when a new capture lands on an unacked result.
module measure_result_reg
  import dfm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr,
  input  logic             cap,
  input  logic [RES_W-1:0] cap_data,
  input  logic             ack,
  output logic             valid,
  output logic [RES_W-1:0] data,
  output logic             overrun
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else if (clr) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (cap) begin
      data  <= cap_data;
      valid <= 1'b1;
      // an ack in the same cycle retires the old word, so no loss
      if (valid && !ack) begin
        overrun <= 1'b1;
      end
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/measure_ctrl.sv
// Measure sequencer: config shadowing, gate control, result
// capture, timeout detection and completed-sample counting.
module measure_ctrl
  import dfm_pkg::*;
#(
  parameter int TIMEOUT_W = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 cont_i,
  input  logic [31:0]          gate_total_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 gate_en_o,
  output logic [31:0]          gate_total_o,
  input  logic                 reg_wr_en_i,
  input  logic [RES_W-1:0]     reg_wr_data_i,
  input  logic                 gate_sync_i,
  output logic                 res_valid_o,
  output logic [RES_W-1:0]     res_data_o,
  input  logic                 res_ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_timeout_o,
  output logic                 overrun_o,
  output logic [CNT_W-1:0]     sample_cnt_o
);

  state_t               state;
  logic                 cont_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [TIMEOUT_W-1:0] tcnt_nxt;
  logic                 cap;
  logic                 clr;
  logic                 tmo_hit;

  assign cap      = reg_wr_en_i && gate_sync_i && (state == RUN);
  assign clr      = start_i && (state == IDLE);
  assign tcnt_nxt = tcnt + TIMEOUT_W'(1);
  assign tmo_hit  = (tmo_q != '0) && (tcnt_nxt == tmo_q);
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      cont_q        <= 1'b0;
      tmo_q         <= '0;
      tcnt          <= '0;
      gate_en_o     <= 1'b0;
      gate_total_o  <= '0;
      done_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      sample_cnt_o  <= '0;
    end else begin
      done_o <= cap;
      if (cap) begin
        sample_cnt_o <= sample_cnt_o + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cont_q        <= cont_i;
            tmo_q         <= timeout_i;
            gate_total_o  <= gate_total_i;
            err_timeout_o <= 1'b0;
            sample_cnt_o  <= '0;
            gate_en_o     <= 1'b1;
            state         <= ARM;
          end
        end
        ARM: begin
          tcnt <= '0;
          if (stop_i) begin
            gate_en_o <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (stop_i) begin
            gate_en_o <= 1'b0;
            state     <= IDLE;
          end else if (cap) begin
            tcnt <= '0;
            if (!cont_q) begin
              gate_en_o <= 1'b0;
              state     <= HOLD;
            end
          end else if (tmo_q != '0) begin
            tcnt <= tcnt_nxt;
            if (tmo_hit) begin
              err_timeout_o <= 1'b1;
              gate_en_o     <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        HOLD: begin
          gate_en_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          gate_en_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  measure_result_reg u_res (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr      (clr),
    .cap      (cap),
    .cap_data (reg_wr_data_i),
    .ack      (res_ack_i),
    .valid    (res_valid_o),
    .data     (res_data_o),
    .overrun  (overrun_o)
  );

endmodule

// File: tb/tb_measure_ctrl.sv
// Directed bench for measure_ctrl: per-cycle vector table plus
// hand sequences for timeout, shadowing and async reset.
module tb_measure_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, cont;
  logic [31:0] gate_total;
  logic [31:0] timeout;
  logic        gate_en;
  logic [31:0] gate_total_q;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        gate_sync;
  logic        res_valid;
  logic [63:0] res_data;
  logic        res_ack;
  logic        busy, done, err_tmo, overrun;
  logic [15:0] sample_cnt;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  measure_ctrl dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .cont_i        (cont),
    .gate_total_i  (gate_total),
    .timeout_i     (timeout),
    .gate_en_o     (gate_en),
    .gate_total_o  (gate_total_q),
    .reg_wr_en_i   (wr_en),
    .reg_wr_data_i (wr_data),
    .gate_sync_i   (gate_sync),
    .res_valid_o   (res_valid),
    .res_data_o    (res_data),
    .res_ack_i     (res_ack),
    .busy_o        (busy),
    .done_o        (done),
    .err_timeout_o (err_tmo),
    .overrun_o     (overrun),
    .sample_cnt_o  (sample_cnt)
  );

  typedef struct {
    logic        start, stop, cont, wr, sync, ack;
    logic [63:0] din;
    logic        gate, busy, valid, done, ovr;
    logic [15:0] cnt;
    logic [63:0] dout;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; stop = 0; wr_en = 0; gate_sync = 0; res_ack = 0;
  endtask

  localparam logic [63:0] D1 = 64'h0000_01F4_0000_000A;

  initial begin
    rst_n = 0; cont = 0; gate_total = 32'd499; timeout = 0;
    wr_data = 0;
    idle_in();

    vec[0]  = '{1,0,0,0,0,0,64'h0,   1,1,0,0,0,0,64'h0};
    vec[1]  = '{0,0,0,0,0,0,64'h0,   1,1,0,0,0,0,64'h0};
    vec[2]  = '{0,0,0,1,0,0,64'hDEAD,1,1,0,0,0,0,64'h0};
    vec[3]  = '{0,0,0,1,1,0,D1,      0,1,1,1,0,1,D1};
    vec[4]  = '{0,0,0,0,0,0,64'h0,   0,0,1,0,0,1,D1};
    vec[5]  = '{0,0,0,0,0,1,64'h0,   0,0,0,0,0,1,D1};
    vec[6]  = '{1,0,1,0,0,0,64'h0,   1,1,0,0,0,0,D1};
    vec[7]  = '{0,0,1,0,0,0,64'h0,   1,1,0,0,0,0,D1};
    vec[8]  = '{0,0,1,1,1,0,64'h11,  1,1,1,1,0,1,64'h11};
    vec[9]  = '{0,0,1,1,1,0,64'h22,  1,1,1,1,1,2,64'h22};
    vec[10] = '{0,0,1,0,0,0,64'h0,   1,1,1,0,1,2,64'h22};
    vec[11] = '{0,0,1,0,0,1,64'h0,   1,1,0,0,1,2,64'h22};
    vec[12] = '{0,1,1,0,0,0,64'h0,   0,0,0,0,1,2,64'h22};
    vec[13] = '{1,0,1,0,0,0,64'h0,   1,1,0,0,0,0,64'h22};
    vec[14] = '{0,0,1,0,0,0,64'h0,   1,1,0,0,0,0,64'h22};
    vec[15] = '{0,0,1,1,1,0,64'h44,  1,1,1,1,0,1,64'h44};
    vec[16] = '{0,0,1,1,1,1,64'h55,  1,1,1,1,0,2,64'h55};
    vec[17] = '{1,1,1,1,1,0,64'h66,  0,0,1,1,1,3,64'h66};

    #12;
    chk("rst_gate", gate_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_gtot", gate_total_q, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 18; i++) begin
      start = vec[i].start; stop = vec[i].stop; cont = vec[i].cont;
      wr_en = vec[i].wr; gate_sync = vec[i].sync;
      res_ack = vec[i].ack; wr_data = vec[i].din;
      tick();
      chk($sformatf("v%0d_gate", i), gate_en, vec[i].gate);
      chk($sformatf("v%0d_busy", i), busy, vec[i].busy);
      chk($sformatf("v%0d_valid", i), res_valid, vec[i].valid);
      chk($sformatf("v%0d_done", i), done, vec[i].done);
      chk($sformatf("v%0d_ovr", i), overrun, vec[i].ovr);
      chk($sformatf("v%0d_cnt", i), sample_cnt, vec[i].cnt);
      chk($sformatf("v%0d_data", i), res_data, vec[i].dout);
      chk($sformatf("v%0d_err", i), err_tmo, 0);
      chk($sformatf("v%0d_gtot", i), gate_total_q, 32'd499);
    end
    idle_in();
    res_ack = 1; tick(); res_ack = 0;

    // continuous: five acked strobes
    cont = 1; start = 1; tick(); start = 0; tick();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; gate_sync = 1; wr_data = 64'(i + 100); tick();
      chk("cont_done", done, 1);
      chk("cont_gate", gate_en, 1);
      wr_en = 0; res_ack = 1; tick(); res_ack = 0;
      chk("cont_ackd", res_valid, 0);
    end
    chk("cont_cnt", sample_cnt, 5);
    chk("cont_ovr", overrun, 0);
    chk("cont_data", res_data, 64'd104);
    stop = 1; tick(); stop = 0;
    chk("cont_stop_busy", busy, 0);
    chk("cont_stop_gate", gate_en, 0);

    // timeout after 100 cycles
    idle_in(); cont = 0; timeout = 100;
    start = 1; tick(); start = 0;
    repeat (100) tick();
    chk("tmo_pre_err", err_tmo, 0);
    chk("tmo_pre_busy", busy, 1);
    tick();
    chk("tmo_err", err_tmo, 1);
    chk("tmo_gate", gate_en, 0);
    chk("tmo_busy", busy, 0);

    // timeout disabled
    timeout = 0; start = 1; tick(); start = 0;
    chk("notmo_clr", err_tmo, 0);
    repeat (10000) tick();
    chk("notmo_err", err_tmo, 0);
    chk("notmo_busy", busy, 1);
    chk("notmo_gate", gate_en, 1);
    stop = 1; tick(); stop = 0;

    // shadowing and start-while-busy
    cont = 1; gate_total = 32'd499; start = 1; tick(); start = 0;
    tick(); gate_total = 32'd7; tick();
    chk("shad_gtot", gate_total_q, 32'd499);
    wr_en = 1; gate_sync = 1; wr_data = 64'h77; tick();
    wr_en = 0; gate_sync = 0;
    start = 1; tick(); start = 0;
    chk("busy_start_gtot", gate_total_q, 32'd499);
    chk("busy_start_cnt", sample_cnt, 1);
    chk("busy_start_valid", res_valid, 1);
    chk("busy_start_busy", busy, 1);
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("ss_busy", busy, 0);
    chk("ss_gate", gate_en, 0);
    start = 1; tick(); start = 0;
    chk("new_gtot", gate_total_q, 32'd7);

    // async reset mid-run with a valid result
    tick();
    wr_en = 1; gate_sync = 1; wr_data = 64'hABC; tick();
    wr_en = 0; gate_sync = 0;
    chk("pre_rst_valid", res_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_data", res_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gate", gate_en, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", sample_cnt, 0);
    chk("arst_gtot", gate_total_q, 0);
    #2 rst_n = 1;
    tick();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
